// File: rtl/sound_pkg.sv
// Shared definitions for the sound pipeline: default count width and a
// ceil(log2) helper used to size prescaler phase registers.
package sound_pkg;

   localparam int COUNT_W = 8;

   // ceil(log2(n)), never less than 1 so a register built from it always exists
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: raises tick for one clk cycle out of every DIV cycles.
// The phase restarts from zero on reset, discarding any partial period.
module tick_gen
   import sound_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int              PW   = clog2_min1(DIV);
   localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

   logic [PW-1:0] phase_r = {PW{1'b0}};

   // With DIV=1, LAST is zero, so phase never leaves 0 and tick stays high.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_r <= {PW{1'b0}};
      end else if (phase_r == LAST) begin
         phase_r <= {PW{1'b0}};
      end else begin
         phase_r <= phase_r + PW'(1);
      end
   end

   assign tick = (phase_r == LAST);

endmodule

// File: rtl/counter.sv
// Free-running modulo-2**WIDTH up-counter advancing once per prescaler tick,
// giving downstream tone/waveform logic a phase or sample index.
module counter
   import sound_pkg::*;
#(
   parameter int               WIDTH = COUNT_W,
   parameter int               DIV   = 1,
   parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] count
);

   logic             tick;
   logic [WIDTH-1:0] count_r = INIT;

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Reset wins over counting; natural wrap from all-ones to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= INIT;
      end else if (tick) begin
         count_r <= count_r + WIDTH'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: default, DIV=4 and INIT=8'hF0 instances,
// table-driven vectors plus hand sequences, checked through a scoreboard queue.
module tb_counter;

   logic       clk = 1'b0;
   logic       rst_def = 1'b0;
   logic       rst_div = 1'b1;
   logic       rst_init = 1'b1;
   logic [7:0] cnt_def;
   logic [7:0] cnt_div;
   logic [7:0] cnt_init;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      int         dut;
      logic [7:0] exp;
   } exp_t;

   typedef struct {
      logic       rst;
      int         cycles;
      logic [7:0] exp_end;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[8];

   always #10 clk = ~clk;

   counter u_def (
      .clk   (clk),
      .reset (rst_def),
      .count (cnt_def)
   );

   counter #(.DIV(4)) u_div (
      .clk   (clk),
      .reset (rst_div),
      .count (cnt_div)
   );

   counter #(.INIT(8'hF0)) u_init (
      .clk   (clk),
      .reset (rst_init),
      .count (cnt_init)
   );

   function automatic logic [7:0] actual(input int d);
      case (d)
         0:       return cnt_def;
         1:       return cnt_div;
         default: return cnt_init;
      endcase
   endfunction

   task automatic compare(input string n, input logic [7:0] a, input logic [7:0] e);
      checks = checks + 1;
      if (a !== e) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d at t=%0t", n, a, e, $time);
      end
   endtask

   task automatic push(input string n, input int d, input logic [7:0] e);
      exp_t x;
      x.name = n;
      x.dut  = d;
      x.exp  = e;
      sb.push_back(x);
   endtask

   // One rising edge, then drain every expectation queued for it.
   task automatic step();
      exp_t x;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         compare(x.name, actual(x.dut), x.exp);
      end
   endtask

   logic [7:0] m_def;

   initial begin
      vecs[0] = '{1'b0,  10, 8'd10};
      vecs[1] = '{1'b1,   1, 8'd0};
      vecs[2] = '{1'b1,  11, 8'd0};
      vecs[3] = '{1'b0,  10, 8'd10};
      vecs[4] = '{1'b1,   1, 8'd0};
      vecs[5] = '{1'b0, 255, 8'd255};
      vecs[6] = '{1'b0,   1, 8'd0};
      vecs[7] = '{1'b0,   3, 8'd3};

      #5;
      compare("powerup_def", cnt_def, 8'd0);
      compare("powerup_div", cnt_div, 8'd0);
      compare("powerup_init", cnt_init, 8'd240);

      m_def = 8'd0;
      for (int i = 0; i < 8; i++) begin
         rst_def = vecs[i].rst;
         for (int c = 0; c < vecs[i].cycles; c++) begin
            m_def = vecs[i].rst ? 8'd0 : m_def + 8'd1;
            push("def_cycle", 0, m_def);
            step();
         end
         compare("def_vec_end", cnt_def, vecs[i].exp_end);
      end

      // DIV=4: release, 12 edges -> 3, then reset mid-prescale
      rst_div = 1'b1;
      push("div_reset", 1, 8'd0);
      step();
      rst_div = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         push("div_count", 1, 8'(e / 4));
         step();
      end
      compare("div_12_edges", cnt_div, 8'd3);
      for (int e = 0; e < 2; e++) begin
         push("div_partial", 1, 8'd3);
         step();
      end
      rst_div = 1'b1;
      push("div_mid_reset", 1, 8'd0);
      step();
      rst_div = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         push("div_phase_discard", 1, 8'd0);
         step();
      end
      push("div_first_after_reset", 1, 8'd1);
      step();

      // INIT=8'hF0: reset value, count up to wrap
      rst_init = 1'b1;
      push("init_reset", 2, 8'd240);
      step();
      push("init_reset_held", 2, 8'd240);
      step();
      rst_init = 1'b0;
      for (int e = 1; e <= 15; e++) begin
         push("init_count", 2, 8'(240 + e));
         step();
      end
      push("init_wrap", 2, 8'd0);
      step();
      push("init_after_wrap", 2, 8'd1);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
